risk_order_arbiter: RTL

- Shares the single stateless risk limiter between NUM_REQ strategy requesters using round-robin valid/ready arbitration.
- Presents one registered order per cycle to the limiter and drives the limiter's kill_enable.
- Supervises the limiter's throttled feedback and auto-trips a latched kill after THROTTLE_TRIP consecutive throttled orders.
- Sits between the strategy kernels and the risk limiter in the PL order path.

---
 rtl/risk_order_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/risk_order_arbiter.sv
`default_nettype none
// ============================================================================
// risk_order_arbiter: round-robin order arbiter in front of the shared risk
// limiter, with a throttle supervisor that latches an auto-kill.
// Revision: 1.0
// ============================================================================
module risk_order_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int THROTTLE_TRIP = 16,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_side,
    input  logic [NUM_REQ*32-1:0]  req_price,
    input  logic [NUM_REQ*32-1:0]  req_qty,
    input  logic                   sw_kill_enable,
    input  logic                   kill_clear,
    output logic                   lim_valid,
    output logic                   lim_side,
    output logic [31:0]            lim_price,
    output logic [31:0]            lim_qty,
    output logic [IDX_W-1:0]       lim_src,
    output logic                   lim_kill_enable,
    input  logic                   lim_throttled,
    output logic [1:0]             state_o,
    output logic [31:0]            sent_count,
    output logic [31:0]            drop_count
);

    localparam logic [1:0]       ST_RUN     = 2'd0;
    localparam logic [1:0]       ST_SW_HALT = 2'd1;
    localparam logic [1:0]       ST_TRIPPED = 2'd2;
    localparam logic [7:0]       TRIP_RUN   = 8'(THROTTLE_TRIP - 1);
    localparam logic [31:0]      CNT_MAX    = 32'hFFFF_FFFF;
    localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       throttle_run_q, throttle_run_d;
    logic             lim_valid_q, lim_valid_d;
    logic             lim_side_q, lim_side_d;
    logic [31:0]      lim_price_q, lim_price_d;
    logic [31:0]      lim_qty_q, lim_qty_d;
    logic [IDX_W-1:0] lim_src_q, lim_src_d;
    logic [31:0]      sent_q, sent_d;
    logic [31:0]      drop_q, drop_d;

    logic             arb_en;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   scan_idx;
    logic             xfer;
    logic             fb_throttled;
    logic             fb_accepted;
    logic             trip;

    assign arb_en = rst_n && (state_q == ST_RUN);

    // Rotating priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!grant_found && req_valid[scan_idx[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign xfer      = arb_en && grant_found;
    assign req_ready = xfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_comb begin
        lim_valid_d = xfer;
        lim_side_d  = lim_side_q;
        lim_price_d = lim_price_q;
        lim_qty_d   = lim_qty_q;
        lim_src_d   = lim_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            lim_side_d  = req_side[grant_idx];
            lim_price_d = req_price[grant_idx*32 +: 32];
            lim_qty_d   = req_qty[grant_idx*32 +: 32];
            lim_src_d   = grant_idx;
            rr_ptr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    assign fb_throttled = lim_valid_q && lim_throttled;
    assign fb_accepted  = lim_valid_q && !lim_throttled;
    assign trip         = fb_throttled && (throttle_run_q == TRIP_RUN);

    always_comb begin
        state_d        = state_q;
        throttle_run_d = throttle_run_q;
        sent_d         = sent_q;
        drop_d         = drop_q;
        if (fb_throttled) begin
            if (drop_q != CNT_MAX) drop_d = drop_q + 32'd1;
            if (throttle_run_q != 8'hFF) throttle_run_d = throttle_run_q + 8'd1;
        end else if (fb_accepted) begin
            if (sent_q != CNT_MAX) sent_d = sent_q + 32'd1;
            throttle_run_d = '0;
        end
        // The trip outranks every other transition, including kill_clear.
        if (trip) begin
            state_d = ST_TRIPPED;
        end else begin
            case (state_q)
                ST_RUN:     if (!sw_kill_enable) state_d = ST_SW_HALT;
                ST_SW_HALT: if (sw_kill_enable)  state_d = ST_RUN;
                ST_TRIPPED: begin
                    if (kill_clear) begin
                        state_d        = sw_kill_enable ? ST_RUN : ST_SW_HALT;
                        throttle_run_d = '0;
                    end
                end
                default:    state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            rr_ptr_q       <= '0;
            throttle_run_q <= '0;
            lim_valid_q    <= 1'b0;
            lim_side_q     <= 1'b0;
            lim_price_q    <= '0;
            lim_qty_q      <= '0;
            lim_src_q      <= '0;
            sent_q         <= '0;
            drop_q         <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            throttle_run_q <= throttle_run_d;
            lim_valid_q    <= lim_valid_d;
            lim_side_q     <= lim_side_d;
            lim_price_q    <= lim_price_d;
            lim_qty_q      <= lim_qty_d;
            lim_src_q      <= lim_src_d;
            sent_q         <= sent_d;
            drop_q         <= drop_d;
        end
    end

    assign lim_valid       = lim_valid_q;
    assign lim_side        = lim_side_q;
    assign lim_price       = lim_price_q;
    assign lim_qty         = lim_qty_q;
    assign lim_src         = lim_src_q;
    assign lim_kill_enable = (state_q == ST_RUN) && sw_kill_enable;
    assign state_o         = state_q;
    assign sent_count      = sent_q;
    assign drop_count      = drop_q;

endmodule
`default_nettype wire
